aes_mixark_serial: RTL and testbench
====================================

AES_MIXARK_SERIAL -- requirements
Module: aes_mixark_serial

Interface
REQ-001 SHALL have no parameters; all widths are fixed by AES-128: state 128 bits, column 32 bits, 4 columns.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  in_state/in_key are valid.
REQ-005 in_ready  output  1  block can accept a new state.
REQ-006 in_state  input  128  post-ShiftRows state; column c = bits [127-32c -: 32], byte 0 in the MSB.
REQ-007 in_key  input  128  round key, same column layout.
REQ-008 last_round  input  1  present only when AES_MIXARK_BYPASS_EN is defined; sampled with in_valid.
REQ-009 out_valid  output  1  out_state holds a finished result.
REQ-010 out_ready  input  1  downstream accepts out_state.
REQ-011 out_state  output  128  MixColumns(in_state) XOR in_key, same layout.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-013 in_ready SHALL be 1 exactly when the FSM is in IDLE.
REQ-014 When the FSM is in IDLE and in_valid=1, the block SHALL latch in_state, in_key (and last_round) at that edge, clear col_cnt to 0 and enter BUSY.
REQ-015 In BUSY, at each edge, the block SHALL replace column col_cnt of the working register with mix(column) XOR key column, then increment col_cnt (2 bits).
REQ-016 When col_cnt=3 in BUSY, the block SHALL write column 3 and enter DONE at that edge (no wrap into column 0).
REQ-017 out_valid SHALL be 1 exactly when the FSM is in DONE; out_state SHALL equal the working register and stay stable while out_valid=1 and out_ready=0.
REQ-018 When the FSM is in DONE and out_ready=1, the block SHALL return to IDLE at that edge.
REQ-019 Latency: the accept edge is edge 0; out_valid SHALL rise after edge 4; minimum initiation interval SHALL be 6 cycles (accept, 4 BUSY cycles, 1 DONE cycle, back to IDLE).
REQ-020 The block SHALL ignore in_valid, in_state and in_key while in BUSY or DONE; latched values SHALL NOT change.
REQ-021 The column mix SHALL be the standard AES GF(2^8) MixColumns with polynomial 0x11B (xtime = shift left, XOR 0x1B on carry-out); all arithmetic SHALL be 8-bit XOR, with no carries.
REQ-022 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-023 While rst=1, the block SHALL go to IDLE, clear col_cnt to 0 and clear the working register to 0; outputs SHALL be in_ready=1, out_valid=0, out_state=0.
REQ-024 A reset asserted in BUSY or DONE SHALL discard the in-flight state with no output handshake; rst SHALL take priority over all other inputs.

Configuration
REQ-025 When AES_MIXARK_BYPASS_EN is defined, port last_round SHALL exist; if the latched last_round=1, each column SHALL be the raw column XOR the key column (MixColumns skipped), with identical timing.
REQ-026 When AES_MIXARK_BYPASS_EN is undefined, port last_round SHALL be absent and MixColumns SHALL always be applied.

Structure
REQ-027 aes_pkg SHALL hold the FSM state enum, AES_COL_W=32, AES_STATE_W=128 and AES_NUM_COLS=4.
REQ-028 The block SHALL instantiate exactly one existing mx column mixer (32-bit in/out), shared across the four columns via a col_cnt-driven mux; no other sub-modules.

Verification
REQ-029 FIPS-197 round 1: in_state=d4bf5d30e0b452aeb84111f11e2798e5, in_key=a0fafe1788542cb123a339392a6c7605 -> out_state=a49c7ff2689f352b6b5bea43026a5049, out_valid rising after edge 4.
REQ-030 Zero key, in_state=db135345 repeated 4 times -> out_state=8e4da1bc repeated 4 times; all-0x01 state -> all-0x01 out_state.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles in DONE while driving new in_valid/data -> out_state stable, in_ready=0, and the result matches the first input only.
REQ-032 Pulse rst in the 2nd BUSY cycle -> next cycle in_ready=1, out_valid=0, out_state=0; a following transaction completes correctly.
REQ-033 With AES_MIXARK_BYPASS_EN defined, last_round=1, state=d4bf5d30..., key=0 -> out_state equals in_state after the same 5-cycle latency.
REQ-034 Back-to-back streaming with out_ready=1 constantly -> one accept every 6 cycles; each output matches a reference model.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 widths, FSM state encoding and the GF(2^8) xtime helper
// used by the serial MixColumns/AddRoundKey block.
package aes_pkg;

   localparam int AES_COL_W    = 32;
   localparam int AES_STATE_W  = 128;
   localparam int AES_NUM_COLS = 4;
   localparam int AES_CNT_W    = $clog2(AES_NUM_COLS);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/mx.sv
// Combinational single-column AES MixColumns; byte 0 of the column sits in the MSBs.
module mx
   import aes_pkg::*;
(
   input  logic [AES_COL_W-1:0] col_in,
   output logic [AES_COL_W-1:0] col_out
);

   logic [7:0] a0, a1, a2, a3;

   assign {a0, a1, a2, a3} = col_in;

   // Rows of the circulant matrix {2,3,1,1}; 3*a is expanded as xtime(a)^a.
   assign col_out = {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
   };

endmodule

// File: rtl/aes_mixark_serial.sv
// Column-serial AES MixColumns + AddRoundKey: one column per cycle through a shared mixer.
// Optional final-round bypass (MixColumns skipped) is enabled by defining AES_MIXARK_BYPASS_EN.
module aes_mixark_serial
   import aes_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_STATE_W-1:0] in_state,
   input  logic [AES_STATE_W-1:0] in_key,
`ifdef AES_MIXARK_BYPASS_EN
   input  logic                   last_round,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_STATE_W-1:0] out_state
);

   state_t                 state;
   logic [AES_CNT_W-1:0]   col_cnt;
   logic [AES_STATE_W-1:0] work_q;
   logic [AES_STATE_W-1:0] key_q;
   logic [AES_COL_W-1:0]   cur_col;
   logic [AES_COL_W-1:0]   key_col;
   logic [AES_COL_W-1:0]   mix_col;
   logic [AES_COL_W-1:0]   new_col;
`ifdef AES_MIXARK_BYPASS_EN
   logic                   last_q;
`endif

   // Steer the column addressed by col_cnt into the single shared mixer.
   always_comb begin
      cur_col = work_q[127:96];
      key_col = key_q[127:96];
      case (col_cnt)
         2'd0: begin cur_col = work_q[127:96]; key_col = key_q[127:96]; end
         2'd1: begin cur_col = work_q[95:64];  key_col = key_q[95:64];  end
         2'd2: begin cur_col = work_q[63:32];  key_col = key_q[63:32];  end
         default: begin cur_col = work_q[31:0]; key_col = key_q[31:0]; end
      endcase
   end

   mx u_mx (
      .col_in  (cur_col),
      .col_out (mix_col)
   );

`ifdef AES_MIXARK_BYPASS_EN
   assign new_col = (last_q ? cur_col : mix_col) ^ key_col;
`else
   assign new_col = mix_col ^ key_col;
`endif

   assign out_state = work_q;

   // Handshake FSM; columns are rewritten in place so the working register
   // becomes the result once column 3 has been written.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         col_cnt   <= '0;
         work_q    <= '0;
         key_q     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
`ifdef AES_MIXARK_BYPASS_EN
         last_q    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work_q   <= in_state;
                  key_q    <= in_key;
                  col_cnt  <= '0;
                  in_ready <= 1'b0;
                  state    <= BUSY;
`ifdef AES_MIXARK_BYPASS_EN
                  last_q   <= last_round;
`endif
               end
            end
            BUSY: begin
               case (col_cnt)
                  2'd0:    work_q[127:96] <= new_col;
                  2'd1:    work_q[95:64]  <= new_col;
                  2'd2:    work_q[63:32]  <= new_col;
                  default: work_q[31:0]   <= new_col;
               endcase
               col_cnt <= col_cnt + AES_CNT_W'(1);
               if (col_cnt == AES_CNT_W'(AES_NUM_COLS - 1)) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_mixark_serial.sv
// Directed, table-driven bench for aes_mixark_serial with an independent GF(2^8) reference model.
// Bypass vectors run only when AES_MIXARK_BYPASS_EN is defined.
module tb_aes_mixark_serial;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic [127:0] in_key;
   logic         last_round;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string        name;
      logic [127:0] state;
      logic [127:0] key;
      logic [127:0] expect_out;
   } vec_t;

   vec_t vecs[5];

   always #5 clk = ~clk;

   aes_mixark_serial dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_state   (in_state),
      .in_key     (in_key),
`ifdef AES_MIXARK_BYPASS_EN
      .last_round (last_round),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_state  (out_state)
   );

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic       hi;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = a << 1;
         if (hi) a = a ^ 8'h1b;
         b  = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] ref_model(input logic [127:0] s, input logic [127:0] k);
      logic [7:0]   coef [4];
      logic [7:0]   acc;
      logic [127:0] r;
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(coef[(j - row + 4) % 4], s[127 - 32*c - 8*j -: 8]);
            r[127 - 32*c - 8*row -: 8] = acc;
         end
      return r ^ k;
   endfunction

   task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Wait for in_ready, present one input for one edge, then count edges to out_valid.
   task automatic applyStimulus(input string name, input logic [127:0] s, input logic [127:0] k,
                                input logic lr, output int lat);
      int guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      cmp({name, "_in_ready"}, 128'(in_ready), 128'(1));
      in_state   = s;
      in_key     = k;
      last_round = lr;
      in_valid   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_state = ~s;
      in_key   = ~k;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic checkOutput(input string name, input logic [127:0] exp, input int lat);
      cmp({name, "_latency"}, 128'(lat), 128'(4));
      cmp({name, "_out_state"}, out_state, exp);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      cmp({name, "_idle"}, {126'(0), in_ready, out_valid}, {126'(0), 2'b10});
   endtask

   initial begin
      int            lat;
      logic [127:0]  snap;
      logic [127:0]  ss  [4];
      logic [127:0]  kk  [4];
      int            acc_cyc [4];
      int            idx;
      int            got;
      logic          stable;
      logic          rdy_low;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; last_round = 1'b0;
      in_state = '0; in_key = '0;

      vecs[0] = '{"fips_r1", 128'hd4bf5d30e0b452aeb84111f11e2798e5,
                  128'ha0fafe1788542cb123a339392a6c7605, 128'ha49c7ff2689f352b6b5bea43026a5049};
      vecs[1] = '{"db135345", {4{32'hdb135345}}, 128'h0, {4{32'h8e4da1bc}}};
      vecs[2] = '{"all01", {16{8'h01}}, 128'h0, {16{8'h01}}};
      vecs[3] = '{"mixed_cols", {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6}, 128'h0,
                  {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6}};
      vecs[4] = '{"ff_key", {32'hd4d4d4d5, 32'h2d26314c, 32'h00000000, 32'hffffffff}, {16{8'hff}},
                  {32'h2a2a2829, 32'hb2814207, 32'hffffffff, 32'h00000000}};

      repeat (3) @(posedge clk);
      @(negedge clk);
      cmp("reset_in_ready", 128'(in_ready), 128'(1));
      cmp("reset_out_valid", 128'(out_valid), 128'(0));
      cmp("reset_out_state", out_state, 128'h0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].name, vecs[i].state, vecs[i].key, 1'b0, lat);
         checkOutput(vecs[i].name, vecs[i].expect_out, lat);
      end

      // Backpressure: hold DONE for 10 cycles while new inputs are offered.
      applyStimulus("bp", vecs[0].state, vecs[0].key, 1'b0, lat);
      snap = out_state;
      stable = 1'b1;
      rdy_low = 1'b1;
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         in_state = 128'(c) * 128'h0123456789abcdef;
         in_key   = ~in_state;
         @(posedge clk);
         @(negedge clk);
         if (out_state !== snap || out_valid !== 1'b1) stable = 1'b0;
         if (in_ready !== 1'b0) rdy_low = 1'b0;
      end
      in_valid = 1'b0;
      cmp("bp_stable", 128'(stable), 128'(1));
      cmp("bp_in_ready_low", 128'(rdy_low), 128'(1));
      checkOutput("bp", vecs[0].expect_out, lat);

      // Reset during the second BUSY cycle.
      @(negedge clk);
      in_state = vecs[1].state; in_key = vecs[1].key; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cmp("rst_busy_in_ready", 128'(in_ready), 128'(1));
      cmp("rst_busy_out_valid", 128'(out_valid), 128'(0));
      cmp("rst_busy_out_state", out_state, 128'h0);
      applyStimulus("post_rst", vecs[3].state, vecs[3].key, 1'b0, lat);
      checkOutput("post_rst", vecs[3].expect_out, lat);

`ifdef AES_MIXARK_BYPASS_EN
      applyStimulus("bypass", vecs[0].state, 128'h0, 1'b1, lat);
      checkOutput("bypass", vecs[0].state, lat);
      applyStimulus("bypass_key", vecs[0].state, vecs[0].key, 1'b1, lat);
      checkOutput("bypass_key", vecs[0].state ^ vecs[0].key, lat);
`endif

      // Streaming with out_ready held high: one accept every 6 cycles.
      for (int i = 0; i < 4; i++) begin
         ss[i] = {$urandom, $urandom, $urandom, $urandom};
         kk[i] = {$urandom, $urandom, $urandom, $urandom};
      end
      out_ready = 1'b1;
      idx = 0;
      got = 0;
      @(negedge clk);
      for (int c = 0; c < 60 && got < 4; c++) begin
         if (out_valid) begin
            cmp($sformatf("stream_out%0d", got), out_state, ref_model(ss[got], kk[got]));
            got++;
         end
         if (in_ready && idx < 4) begin
            in_state = ss[idx]; in_key = kk[idx]; in_valid = 1'b1;
            acc_cyc[idx] = c;
            idx++;
         end else if (idx < 4) begin
            in_state = ~ss[idx]; in_key = kk[idx] ^ 128'h5a; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      cmp("stream_count", 128'(got), 128'(4));
      for (int i = 1; i < 4; i++)
         cmp($sformatf("stream_ii%0d", i), 128'(acc_cyc[i] - acc_cyc[i-1]), 128'(6));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
